fir_y_requant: RTL

- Output requantization stage between the FIR datapath's wide accumulator stream and the streamer's y sink.
- Per sample: optional round-half-up, arithmetic right shift, saturation to signed DATA_WIDTH; counts samples and saturation events.
- 2-stage valid/ready pipeline with its own IDLE/RUN/DRAIN FSM; configured per job by the FIR controller, reports done/saturation flags back to it.

---
 rtl/fir_y_requant_pkg.sv | 33 +++
 rtl/fir_y_requant_sat.sv | 47 ++++
 rtl/fir_y_requant.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fir_y_requant_pkg.sv
// +--------------------------------------------------------------------------+
// | fir_y_requant_pkg : shared types for the FIR output requantization stage |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_y_requant_pkg;

  localparam int FIR_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } fir_requant_state_e;

  typedef struct packed {
    logic                     start;
    logic [5:0]               shift;
    logic                     round_en;
    logic [FIR_CNT_WIDTH-1:0] nb_outputs;
  } fir_requant_ctrl_t;

  typedef struct packed {
    logic                     busy;
    logic                     done;
    logic [FIR_CNT_WIDTH-1:0] out_cnt;
    logic [FIR_CNT_WIDTH-1:0] sat_cnt;
  } fir_requant_flags_t;

endpackage

`default_nettype wire

// File: rtl/fir_y_requant_sat.sv
// +--------------------------------------------------------------------------+
// | fir_y_requant_sat : combinational round-half-up, shift, saturate         |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_y_requant_sat #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 38
) (
  input  logic [ACC_WIDTH-1:0]  i_acc,
  input  logic [5:0]            i_shift,
  input  logic                  i_round_en,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_sat
);

  // One extra bit of headroom so the rounding offset can never overflow.
  localparam logic signed [ACC_WIDTH:0] C_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] C_MIN = ~C_MAX;

  logic        [ACC_WIDTH:0] w_rnd;
  logic signed [ACC_WIDTH:0] w_t;
  logic signed [ACC_WIDTH:0] w_r;

  assign w_rnd = (i_round_en && (i_shift != 6'd0))
               ? ((ACC_WIDTH+1)'(1) << (i_shift - 6'd1))
               : '0;
  assign w_t   = $signed({i_acc[ACC_WIDTH-1], i_acc}) + $signed(w_rnd);
  assign w_r   = w_t >>> i_shift;

  always_comb begin
    o_sat  = 1'b0;
    o_data = w_r[DATA_WIDTH-1:0];
    if (w_r > C_MAX) begin
      o_sat  = 1'b1;
      o_data = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end else if (w_r < C_MIN) begin
      o_sat  = 1'b1;
      o_data = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    end
  end

endmodule

`default_nettype wire

// File: rtl/fir_y_requant.sv
// +--------------------------------------------------------------------------+
// | fir_y_requant : 2-stage requantization pipeline, accumulator -> y stream |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_y_requant
  import fir_y_requant_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 38,
  parameter int CNT_WIDTH  = FIR_CNT_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  fir_requant_ctrl_t       ctrl_i,
  output fir_requant_flags_t      flags_o,
  input  logic                    y_acc_valid_i,
  input  logic [ACC_WIDTH-1:0]    y_acc_data_i,
  output logic                    y_acc_ready_o,
  output logic                    y_out_valid_o,
  output logic [DATA_WIDTH-1:0]   y_out_data_o,
  output logic [DATA_WIDTH/8-1:0] y_out_strb_o,
  input  logic                    y_out_ready_i
);

  localparam logic [5:0]           C_SHIFT_MAX = 6'(ACC_WIDTH-1);
  localparam logic [CNT_WIDTH-1:0] C_ONE       = CNT_WIDTH'(1);

  fir_requant_state_e    r_state;
  logic [5:0]            r_shift;
  logic                  r_round;
  logic [CNT_WIDTH-1:0]  r_nb;
  logic [CNT_WIDTH-1:0]  r_in_cnt;
  logic [CNT_WIDTH-1:0]  r_out_cnt;
  logic [CNT_WIDTH-1:0]  r_sat_cnt;
  logic                  r_v0;
  logic [ACC_WIDTH-1:0]  r_d0;
  logic                  r_v1;
  logic [DATA_WIDTH-1:0] r_d1;
  logic                  r_sat1;

  logic                  w_s1_ready;
  logic                  w_s0_ready;
  logic                  w_in_hs;
  logic                  w_out_hs;
  logic                  w_last_out;
  logic [5:0]            w_shift_cl;
  logic [DATA_WIDTH-1:0] w_q_data;
  logic                  w_q_sat;

  assign w_s1_ready    = !r_v1 || y_out_ready_i;
  assign w_s0_ready    = !r_v0 || w_s1_ready;
  assign y_acc_ready_o = (r_state == ST_RUN) && w_s0_ready && (r_in_cnt < r_nb);
  assign w_in_hs       = y_acc_valid_i && y_acc_ready_o;
  assign w_out_hs      = r_v1 && y_out_ready_i;
  assign w_last_out    = (r_state == ST_DRAIN) && w_out_hs && (r_out_cnt == r_nb - C_ONE);
  assign w_shift_cl    = (ctrl_i.shift > C_SHIFT_MAX) ? C_SHIFT_MAX : ctrl_i.shift;

  fir_y_requant_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat (
    .i_acc      (r_d0),
    .i_shift    (r_shift),
    .i_round_en (r_round),
    .o_data     (w_q_data),
    .o_sat      (w_q_sat)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_round   <= 1'b0;
      r_nb      <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_sat_cnt <= '0;
      r_v0      <= 1'b0;
      r_d0      <= '0;
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_sat1    <= 1'b0;
    end else if (clear_i) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_round   <= 1'b0;
      r_nb      <= '0;
      r_in_cnt  <= '0;
      r_out_cnt <= '0;
      r_sat_cnt <= '0;
      r_v0      <= 1'b0;
      r_d0      <= '0;
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_sat1    <= 1'b0;
    end else begin
      if (w_in_hs) begin
        r_in_cnt <= r_in_cnt + C_ONE;
      end
      if (w_out_hs) begin
        r_out_cnt <= r_out_cnt + C_ONE;
        if (r_sat1 && (r_sat_cnt != '1)) begin
          r_sat_cnt <= r_sat_cnt + C_ONE;
        end
      end

      // Stage 1 refills whenever it drains, so a simultaneous in/out handshake leaves no bubble.
      if (r_v0 && w_s1_ready) begin
        r_v1   <= 1'b1;
        r_d1   <= w_q_data;
        r_sat1 <= w_q_sat;
      end else if (w_out_hs) begin
        r_v1 <= 1'b0;
      end

      if (w_in_hs) begin
        r_v0 <= 1'b1;
        r_d0 <= y_acc_data_i;
      end else if (r_v0 && w_s1_ready) begin
        r_v0 <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (ctrl_i.start && (ctrl_i.nb_outputs != '0)) begin
            r_shift   <= w_shift_cl;
            r_round   <= ctrl_i.round_en;
            r_nb      <= ctrl_i.nb_outputs;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
            r_sat_cnt <= '0;
            r_state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_in_hs && (r_in_cnt == r_nb - C_ONE)) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_last_out) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign y_out_valid_o   = r_v1;
  assign y_out_data_o    = r_d1;
  assign y_out_strb_o    = '1;

  assign flags_o.busy    = (r_state != ST_IDLE);
  assign flags_o.done    = w_last_out;
  assign flags_o.out_cnt = r_out_cnt;
  assign flags_o.sat_cnt = r_sat_cnt;

endmodule

`default_nettype wire
